sd_sector_buffer: RTL

Host-side sector buffer sitting directly upstream of the SD card controller. It holds one 512-byte sector in an internal RAM and turns a single host request into an `op_code`/`execute` command with a sector address. It streams RAM bytes onto `outgoing_byte` for writes and captures `incoming_byte` into RAM for reads, counting bytes on `finished_byte` and closing on `finished_sector`. It reports completion, byte-count errors and timeouts back to the host.

---
 rtl/sd_sector_buffer_if.sv | 39 +++
 rtl/sd_sector_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sd_sector_buffer_if.sv
// Host and SD-controller signal bundle for the sector buffer.
// The slave modport is the buffer; the master modport is whatever drives host and controller sides.
interface sd_sector_buffer_if #(
  parameter int ADDR_W = 9
);
  logic              host_req;
  logic              host_write;
  logic [25:0]       host_sector;
  logic              host_wr_en;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic [7:0]        host_rdata;
  logic              host_busy;
  logic              host_done;
  logic              host_error;
  logic [1:0]        err_code;
  logic              op_code;
  logic              execute;
  logic [25:0]       sector_address;
  logic [7:0]        outgoing_byte;
  logic [7:0]        incoming_byte;
  logic              finished_byte;
  logic              finished_sector;
  logic              ctrl_busy;

  modport slave (
    input  host_req, host_write, host_sector, host_wr_en, host_addr, host_wdata,
    input  incoming_byte, finished_byte, finished_sector, ctrl_busy,
    output host_rdata, host_busy, host_done, host_error, err_code,
    output op_code, execute, sector_address, outgoing_byte
  );

  modport master (
    output host_req, host_write, host_sector, host_wr_en, host_addr, host_wdata,
    output incoming_byte, finished_byte, finished_sector, ctrl_busy,
    input  host_rdata, host_busy, host_done, host_error, err_code,
    input  op_code, execute, sector_address, outgoing_byte
  );
endinterface

// File: rtl/sd_sector_buffer.sv
// One-sector RAM buffer between a host and an SD card controller: turns a host request
// into a single execute command and streams bytes between RAM and the controller.
module sd_sector_buffer #(
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  sd_sector_buffer_if.slave bus
);
  localparam int AW = $clog2(SECTOR_BYTES);
  localparam int IW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] FULL  = IW'(SECTOR_BYTES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREFETCH = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ERROR    = 3'd5;

  logic [7:0]    ram [SECTOR_BYTES];
  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic          long_flag;
  logic          fbyte_p1;
  logic          fsec_p1;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err;
  logic          op_write;
  logic          execute;
  logic [25:0]   sector;
  logic [7:0]    out_byte;
  logic [7:0]    rdata;

  logic          byte_edge;
  logic          sec_edge;
  logic          byte_take;
  logic          byte_over;
  logic [IW-1:0] idx_upd;
  logic          long_upd;
  logic [AW-1:0] next_addr;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;

  // Byte handling resolves first so a coincident sector edge sees the updated index.
  always_comb begin
    byte_edge = (state == S_STREAM) && bus.finished_byte && !fbyte_p1;
    sec_edge  = (state == S_STREAM) && bus.finished_sector && !fsec_p1;
    byte_take = byte_edge && (idx != FULL);
    byte_over = byte_edge && (idx == FULL);
    idx_upd   = byte_take ? idx + 1'b1 : idx;
    long_upd  = long_flag | byte_over;
    next_addr = idx[AW-1:0] + 1'b1;

    ram_we    = 1'b0;
    ram_waddr = bus.host_addr;
    ram_wdata = bus.host_wdata;
    if (!rst) begin
      if (!busy && bus.host_wr_en) begin
        ram_we = 1'b1;
      end else if (byte_take && !op_write) begin
        ram_we    = 1'b1;
        ram_waddr = idx[AW-1:0];
        ram_wdata = bus.incoming_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      tcnt      <= '0;
      long_flag <= 1'b0;
      fbyte_p1  <= 1'b0;
      fsec_p1   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err       <= 2'd0;
      op_write  <= 1'b0;
      execute   <= 1'b0;
      sector    <= '0;
      out_byte  <= 8'h00;
      rdata     <= 8'h00;
    end else begin
      fbyte_p1 <= bus.finished_byte;
      fsec_p1  <= bus.finished_sector;
      execute  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      rdata    <= ram[bus.host_addr];
      case (state)
        S_IDLE: begin
          if (bus.host_req) begin
            op_write  <= bus.host_write;
            sector    <= bus.host_sector;
            err       <= 2'd0;
            idx       <= '0;
            tcnt      <= '0;
            long_flag <= 1'b0;
            busy      <= 1'b1;
            state     <= bus.host_write ? S_PREFETCH : S_ISSUE;
          end
        end
        S_PREFETCH: begin
          out_byte <= ram[0];
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!bus.ctrl_busy) begin
            execute <= 1'b1;
            tcnt    <= '0;
            state   <= S_STREAM;
          end else if (tcnt == TLAST) begin
            error <= 1'b1;
            err   <= 2'd3;
            state <= S_ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_STREAM: begin
          idx       <= idx_upd;
          long_flag <= long_upd;
          if (byte_take && op_write) out_byte <= ram[next_addr];
          if (sec_edge) begin
            if (long_upd) begin
              error <= 1'b1;
              err   <= 2'd2;
              state <= S_ERROR;
            end else if (idx_upd == FULL) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              error <= 1'b1;
              err   <= 2'd1;
              state <= S_ERROR;
            end
          end else if (byte_edge) begin
            tcnt <= '0;
          end else if (tcnt == TLAST) begin
            error <= 1'b1;
            err   <= 2'd3;
            state <= S_ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE, S_ERROR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.host_rdata     = rdata;
  assign bus.host_busy      = busy;
  assign bus.host_done      = done;
  assign bus.host_error     = error;
  assign bus.err_code       = err;
  assign bus.op_code        = op_write;
  assign bus.execute        = execute;
  assign bus.sector_address = sector;
  assign bus.outgoing_byte  = out_byte;
endmodule
